lcd_hd44780_rx: RTL and testbench

- Responder end of the 4-bit HD44780 LCD bus that the namebadge drives on RS, E and D[3:0].
- Samples the bus and reassembles nibbles into command and data bytes. Decodes the command subset the badge uses and holds a 2x16 character buffer.
- Used as a synthesizable display model in simulation and gate-level benches, and as a loopback checker on hardware.

---
 rtl/lcd_hd44780_rx.sv | 185 ++++++++++++++++++
 tb/tb_lcd_hd44780_rx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_rx.sv
// Responder end of a 4-bit HD44780 bus: synchronizes RS/E/D, rebuilds bytes, decodes commands, holds 2x16 cells.
// Latency: byte_valid SYNC_STAGES+1 cycles after E falls at the pin; clear holds busy for CLEAR_CYCLES cycles.
// No backpressure: strobes while busy are reported but not executed. Error counter built only with LCD_RX_ERRCNT_EN.
module lcd_hd44780_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int CLEAR_CYCLES = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RS,
  input  logic       E,
  input  logic [3:0] D,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic       mode4,
  output logic       display_on,
  output logic       busy,
  output logic [6:0] cursor,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {INIT8 = 2'd0, HI = 2'd1, LO = 2'd2} state_t;

  localparam logic [4:0] CLR_LAST = 5'(CLEAR_CYCLES - 1);

  state_t                      state_q;
  logic [SYNC_STAGES-1:0]      e_sync_q;
  logic [SYNC_STAGES-1:0]      rs_sync_q;
  logic [SYNC_STAGES-1:0][3:0] d_sync_q;
  logic                        e_prev_q;
  logic [3:0]                  hi_q;
  logic [7:0]                  buf_q [32];
  logic                        byte_valid_q;
  logic [7:0]                  byte_out_q;
  logic                        byte_rs_q;
  logic                        mode4_q;
  logic                        display_on_q;
  logic                        busy_q;
  logic                        inc_q;
  logic [6:0]                  cursor_q;
  logic [4:0]                  clr_idx_q;

  logic       e_s;
  logic       rs_s;
  logic [3:0] d_s;
  logic       fall;
  logic       byte_strobe;
  logic       exec;
  logic [7:0] rx_byte;
  logic       cell_ok;
  logic [4:0] cell_idx;
  logic [6:0] cursor_step;

  // Strobe detection, byte assembly and cursor arithmetic for the current cycle.
  always_comb begin
    e_s         = e_sync_q[SYNC_STAGES-1];
    rs_s        = rs_sync_q[SYNC_STAGES-1];
    d_s         = d_sync_q[SYNC_STAGES-1];
    fall        = e_prev_q & ~e_s;
    rx_byte     = (state_q == LO) ? {hi_q, d_s} : {d_s, 4'h0};
    byte_strobe = fall && (state_q != HI);
    exec        = byte_strobe && !busy_q;
    // Line 1 lives at 0x00-0x0F, line 2 at 0x40-0x4F; bit 6 picks the line.
    cell_ok     = (cursor_q[6:4] == 3'b000) || (cursor_q[6:4] == 3'b100);
    cell_idx    = {cursor_q[6], cursor_q[3:0]};
    cursor_step = cursor_q;
    if (inc_q) begin
      if (cursor_q == 7'h27)      cursor_step = 7'h40;
      else if (cursor_q == 7'h67) cursor_step = 7'h00;
      else                        cursor_step = cursor_q + 7'd1;
    end else begin
      if (cursor_q == 7'h00)      cursor_step = 7'h67;
      else if (cursor_q == 7'h40) cursor_step = 7'h27;
      else                        cursor_step = cursor_q - 7'd1;
    end
  end

  // Bus synchronizers, nibble FSM, command/data execution and clear sweep.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= INIT8;
      e_sync_q     <= '0;
      rs_sync_q    <= '0;
      d_sync_q     <= '0;
      e_prev_q     <= 1'b0;
      hi_q         <= 4'h0;
      byte_valid_q <= 1'b0;
      byte_out_q   <= 8'h00;
      byte_rs_q    <= 1'b0;
      mode4_q      <= 1'b0;
      display_on_q <= 1'b0;
      busy_q       <= 1'b0;
      inc_q        <= 1'b1;
      cursor_q     <= 7'h00;
      clr_idx_q    <= 5'd0;
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else begin
      e_sync_q     <= {e_sync_q[SYNC_STAGES-2:0], E};
      rs_sync_q    <= {rs_sync_q[SYNC_STAGES-2:0], RS};
      d_sync_q     <= {d_sync_q[SYNC_STAGES-2:0], D};
      e_prev_q     <= e_s;
      byte_valid_q <= 1'b0;

      // Clear sweep: one cell per cycle; data writes cannot collide since they are blocked while busy.
      if (busy_q) begin
        buf_q[clr_idx_q] <= 8'h20;
        clr_idx_q        <= clr_idx_q + 5'd1;
        if (clr_idx_q == CLR_LAST) busy_q <= 1'b0;
      end

      if (fall && state_q == HI) begin
        hi_q    <= d_s;
        state_q <= LO;
      end else if (byte_strobe) begin
        byte_valid_q <= 1'b1;
        byte_out_q   <= rx_byte;
        byte_rs_q    <= rs_s;
        if (state_q == LO) state_q <= HI;
        if (exec) begin
          if (rs_s) begin
            if (cell_ok) buf_q[cell_idx] <= rx_byte;
            cursor_q <= cursor_step;
          end else begin
            casez (rx_byte)
              8'b1???????: cursor_q <= rx_byte[6:0];
              8'b01??????: ;
              8'b001?????: begin
                if (!rx_byte[4]) begin
                  if (state_q == INIT8) begin
                    state_q <= HI;
                    mode4_q <= 1'b1;
                  end
                end else if (state_q == LO) begin
                  state_q <= INIT8;
                  mode4_q <= 1'b0;
                end
              end
              8'b0001????: ;
              8'b00001???: display_on_q <= rx_byte[2];
              8'b000001??: inc_q <= rx_byte[1];
              8'b0000001?: cursor_q <= 7'h00;
              8'b00000001: begin
                cursor_q  <= 7'h00;
                inc_q     <= 1'b1;
                busy_q    <= 1'b1;
                clr_idx_q <= 5'd0;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

`ifdef LCD_RX_ERRCNT_EN
  logic [7:0] err_q;

  // Saturating count of bytes decoded during a clear or data bytes seen before 4-bit mode.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      err_q <= 8'h00;
    end else if (byte_strobe && (busy_q || (rs_s && state_q == INIT8)) && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

  assign rd_data    = buf_q[rd_addr];
  assign byte_valid = byte_valid_q;
  assign byte_out   = byte_out_q;
  assign byte_rs    = byte_rs_q;
  assign mode4      = mode4_q;
  assign display_on = display_on_q;
  assign busy       = busy_q;
  assign cursor     = cursor_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Bench for lcd_hd44780_rx: directed scenarios plus random traffic against a byte-level display model.
module tb_lcd_hd44780_rx;
  localparam int S = 2;
`ifdef LCD_RX_ERRCNT_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       RST, RS, E;
  logic [3:0] D;
  logic [4:0] rd_addr;
  logic [7:0] rd_data, byte_out, err_count;
  logic       byte_valid, byte_rs, mode4, display_on, busy;
  logic [6:0] cursor;

  lcd_hd44780_rx #(.SYNC_STAGES(S), .CLEAR_CYCLES(32)) dut (
    .CLK(clk), .RST(RST), .RS(RS), .E(E), .D(D), .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs), .mode4(mode4),
    .display_on(display_on), .busy(busy), .cursor(cursor), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_smp = 1'b1;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= RST;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural display model ----------------
  typedef struct {int apply; bit rs; logic [3:0] d;} stb_t;
  stb_t q[$];

  logic [7:0] m_cell [32];
  logic [6:0] m_cur;
  logic [3:0] m_hi;
  logic [7:0] m_bout;
  bit m_four, m_have_hi, m_inc, m_disp, m_brs, exp_bv, started;
  int m_err, clr_start, n_bv, busy_run, last_busy_run;

  function automatic bit in_busy(input int c);
    return (c >= clr_start) && (c < clr_start + 32);
  endfunction

  function automatic int exp_err();
    return ERR_ON ? m_err : 0;
  endfunction

  task automatic model_reset();
    m_four = 0; m_have_hi = 0; m_hi = 0; m_cur = 0; m_inc = 1; m_disp = 0;
    m_bout = 0; m_brs = 0; m_err = 0; clr_start = -1000;
    for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
  endtask

  // Cursor walks a ring of 80 positions (40 per line); unmapped addresses just count by one.
  task automatic model_step();
    int line, col, pos;
    line = (m_cur >= 7'h40) ? 1 : 0;
    col  = int'(m_cur) - 64 * line;
    if (col <= 39) begin
      pos = line * 40 + col;
      pos = m_inc ? (pos + 1) % 80 : (pos + 79) % 80;
      m_cur = 7'((pos / 40) * 64 + pos % 40);
    end else begin
      m_cur = m_inc ? m_cur + 7'd1 : m_cur - 7'd1;
    end
  endtask

  task automatic model_strobe(input bit rs, input logic [3:0] d);
    bit bz, was_lo;
    logic [7:0] b;
    bz = in_busy(cyc - 1);
    if (m_four && !m_have_hi) begin
      m_hi = d; m_have_hi = 1;
      return;
    end
    was_lo = m_four;
    b = m_four ? {m_hi, d} : {d, 4'h0};
    m_have_hi = 0;
    exp_bv = 1; m_bout = b; m_brs = rs;
    if ((bz || (rs && !m_four)) && m_err < 255) m_err++;
    if (bz) return;
    if (rs) begin
      if (m_cur < 16) m_cell[m_cur] = b;
      else if (m_cur >= 7'h40 && m_cur < 7'h50) m_cell[int'(m_cur) - 64 + 16] = b;
      model_step();
    end else if (b >= 8'h80) m_cur = b[6:0];
    else if (b >= 8'h40) begin end
    else if (b >= 8'h20) begin
      if (!b[4]) m_four = 1;
      else if (was_lo) m_four = 0;
    end
    else if (b >= 8'h10) begin end
    else if (b >= 8'h08) m_disp = b[2];
    else if (b >= 8'h04) m_inc = b[1];
    else if (b >= 8'h02) m_cur = 0;
    else if (b == 8'h01) begin
      m_cur = 0; m_inc = 1; clr_start = cyc;
      for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
    end
  endtask

  // Per-cycle compare of every DUT output against the model.
  initial begin
    stb_t s;
    rd_addr = 5'd0; started = 0; n_bv = 0; busy_run = 0; last_busy_run = 0;
    model_reset();
    forever begin
      @(negedge clk);
      exp_bv = 0;
      if (!rst_smp) begin
        started = 1; model_reset(); q.delete(); busy_run = 0;
      end else begin
        while (q.size() > 0 && q[0].apply <= cyc) begin
          s = q.pop_front();
          if (s.apply == cyc) model_strobe(s.rs, s.d);
        end
      end
      if (started) begin
        chk("byte_valid", byte_valid, exp_bv);
        chk("byte_out", byte_out, m_bout);
        chk("byte_rs", byte_rs, m_brs);
        chk("mode4", mode4, m_four);
        chk("display_on", display_on, m_disp);
        chk("busy", busy, in_busy(cyc));
        chk("cursor", cursor, m_cur);
        chk("err_count", err_count, exp_err());
        if (!in_busy(cyc)) chk("rd_data", rd_data, m_cell[rd_addr]);
        if (byte_valid === 1'b1) n_bv++;
        if (busy === 1'b1) busy_run++;
        else if (busy_run > 0) begin last_busy_run = busy_run; busy_run = 0; end
      end
      rd_addr = rd_addr + 5'd1;
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic strobe(input bit rs, input logic [3:0] d, input int h, input int l);
    stb_t s;
    RS = rs; D = d; E = 1'b1;
    idle(h);
    E = 1'b0;
    s.apply = cyc + S + 1; s.rs = rs; s.d = d;
    q.push_back(s);
    idle(l);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    strobe(rs, b[7:4], $urandom_range(1, 4), $urandom_range(S + 1, S + 4));
    strobe(rs, b[3:0], $urandom_range(1, 4), $urandom_range(S + 1, S + 4));
  endtask

  task automatic do_reset(input int n);
    RST = 1'b0;
    idle(n);
    RST = 1'b1;
  endtask

  task automatic wait_busy(input logic val, input int limit);
    int k;
    k = 0;
    while (busy !== val && k < limit) begin idle(1); k++; end
    if (busy !== val) begin
      n_cmp++; n_err++;
      $display("FAIL wait_busy: busy stuck at %b, wanted %b", busy, val);
    end
  endtask

  task automatic init4();
    strobe(0, 4'h3, 2, 4); strobe(0, 4'h3, 2, 4); strobe(0, 4'h3, 2, 4); strobe(0, 4'h2, 2, 4);
  endtask

  initial begin
    int bv0, r;
    logic [7:0] b;
    RS = 0; E = 0; D = 0; RST = 0;
    idle(3);
    RST = 1;
    idle(2);
    chk("reset_mode4", mode4, 0);
    chk("reset_cursor", cursor, 0);
    chk("reset_byte_out", byte_out, 0);
    chk("reset_err", err_count, 0);

    // Init sequence into 4-bit mode
    bv0 = n_bv;
    init4();
    idle(3);
    chk("init_pulses", n_bv - bv0, 4);
    chk("init_mode4", mode4, 1);
    chk("init_last_byte", byte_out, 8'h20);

    // Text write
    send_byte(0, 8'h0C); send_byte(1, 8'h48); send_byte(1, 8'h69);
    idle(3);
    chk("text_display_on", display_on, 1);
    chk("text_cursor", cursor, 7'h02);
    chk("text_cell0_model", m_cell[0], 8'h48);
    chk("text_cell1_model", m_cell[1], 8'h69);
    chk("text_byte_out", byte_out, 8'h69);
    chk("text_byte_rs", byte_rs, 1);

    // Line 2 end and past-the-window write
    send_byte(0, 8'hCF); send_byte(1, 8'h41); send_byte(1, 8'h42);
    idle(3);
    chk("wrap_cursor", cursor, 7'h51);
    chk("wrap_cell31_model", m_cell[31], 8'h41);
    chk("wrap_cell30_model", m_cell[30], 8'h20);
    idle(34);

    // Clear display
    send_byte(0, 8'h01);
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 60);
    idle(2);
    chk("clear_busy_len", last_busy_run, 32);
    chk("clear_cursor", cursor, 0);
    chk("clear_cell0_model", m_cell[0], 8'h20);
    idle(34);

    // Data byte during a clear
    send_byte(0, 8'h01);
    wait_busy(1'b1, 20);
    idle(5);
    bv0 = n_bv;
    send_byte(1, 8'h5A);
    idle(3);
    chk("busy_viol_pulse", n_bv - bv0, 1);
    wait_busy(1'b0, 60);
    idle(2);
    chk("busy_viol_err", err_count, ERR_ON);
    chk("busy_viol_cursor", cursor, 0);
    idle(34);

    // Reset with half a byte received
    send_byte(1, 8'h78);
    idle(3);
    chk("pre_reset_model_cell0", m_cell[0], 8'h78);
    bv0 = n_bv;
    strobe(1, 4'h4, 2, S + 2);
    do_reset(1);
    idle(40);
    chk("midbyte_no_pulse", n_bv - bv0, 0);
    chk("midbyte_mode4", mode4, 0);
    chk("midbyte_byte_out", byte_out, 0);
    chk("midbyte_cell0_model", m_cell[0], 8'h20);

    // Random traffic
    init4();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      case (r)
        0: send_byte(0, 8'h01);
        1: send_byte(0, 8'h02);
        2: send_byte(0, 8'h04 | 8'($urandom_range(0, 3)));
        3: send_byte(0, 8'h08 | 8'($urandom_range(0, 7)));
        4, 5: send_byte(0, 8'h80 | 8'($urandom_range(0, 127)));
        6: send_byte(0, 8'h10 | 8'($urandom_range(0, 15)));
        7: send_byte(0, 8'h40 | 8'($urandom_range(0, 63)));
        8: send_byte(0, 8'h28);
        9: send_byte(0, 8'h00);
        10: begin
          send_byte(0, 8'h30);
          if ($urandom_range(0, 1) == 1) strobe(1, 4'($urandom_range(0, 15)), 2, 4);
          strobe(0, 4'h2, 2, 4);
        end
        default: begin
          b = 8'($urandom_range(32, 126));
          send_byte(1, b);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 40));
    end
    idle(50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
